// File: rtl/reg_file_param_if.sv
// Read/write bus of the parametrised register file.
// The master drives requests and the write port; the slave returns the read results.
interface reg_file_param_if #(
   parameter int DW = 16,
   parameter int AW = 2
);
   logic          en_in;
   logic          in_ready;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] rs_addr;
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic          en_out;
   logic          out_ready;
   logic [DW-1:0] rd_q;
   logic [DW-1:0] rs_q;

   modport master (
      output en_in, rd_addr, rs_addr, we, wa, wd, out_ready,
      input  in_ready, en_out, rd_q, rs_q
   );

   modport slave (
      input  en_in, rd_addr, rs_addr, we, wa, wd, out_ready,
      output in_ready, en_out, rd_q, rs_q
   );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised GPR file: one write port, two registered read ports behind a
// valid/ready handshake, with optional write bypass and hard-wired zero register.
module reg_file_param #(
   parameter int DW      = 16,
   parameter int NREG    = 4,
   parameter int AW      = 2,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input logic             clk,
   input logic             rst,
   reg_file_param_if.slave bus
);
   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   logic [NREG-1:0][DW-1:0] mem;
   logic [AW-1:0]           wa;
   logic [DW-1:0]           wd;
   logic                    wr_ok;
   logic                    accept;
   logic                    en_r;
   logic [DW-1:0]           rd_r, rs_r, rd_v, rs_v;

   assign wa     = bus.wa;
   assign wd     = bus.wd;
   assign wr_ok  = bus.we && ({1'b0, wa} < NREG_W) && !(ZERO_R0 != 0 && wa == '0);
   assign accept = bus.en_in && bus.in_ready;

   // Read value: out-of-range and the zero register read 0; bypass sees this cycle's write.
   function automatic logic [DW-1:0] rv(input logic [AW-1:0] a);
      rv = '0;
      if (({1'b0, a} < NREG_W) && !(ZERO_R0 != 0 && a == '0)) begin
         if (BYPASS != 0 && wr_ok && wa == a) rv = wd;
         else
            for (int i = 0; i < NREG; i++)
               if (a == AW'(i)) rv = mem[i];
      end
   endfunction

   always_comb begin
      rd_v = rv(bus.rd_addr);
      rs_v = rv(bus.rs_addr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem <= '0;
      else if (wr_ok)
         for (int i = 0; i < NREG; i++)
            if (wa == AW'(i)) mem[i] <= wd;
   end

   // Held results are snapshots; only a new accept replaces them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_r <= 1'b0;
         rd_r <= '0;
         rs_r <= '0;
      end else if (accept) begin
         en_r <= 1'b1;
         rd_r <= rd_v;
         rs_r <= rs_v;
      end else if (en_r && bus.out_ready) begin
         en_r <= 1'b0;
      end
   end

   assign bus.in_ready = !en_r || bus.out_ready;
   assign bus.en_out   = en_r;
   assign bus.rd_q     = rd_r;
   assign bus.rs_q     = rs_r;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three configurations (default, no bypass, NREG=3 with
// zero register) share one stimulus stream and are checked against a scoreboard model.
module tb_reg_file_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        en_in = 0, we = 0, out_ready = 0;
   logic [1:0]  rd_addr = 0, rs_addr = 0, wa = 0;
   logic [15:0] wd = 0;
   logic        en_o [3];
   logic        irdy [3];
   logic [15:0] rdq [3];
   logic [15:0] rsq [3];

   reg_file_param_if #(.DW(16), .AW(2)) bus [3] ();

   for (genvar k = 0; k < 3; k++) begin : g_dut
      assign bus[k].en_in     = en_in;
      assign bus[k].rd_addr   = rd_addr;
      assign bus[k].rs_addr   = rs_addr;
      assign bus[k].we        = we;
      assign bus[k].wa        = wa;
      assign bus[k].wd        = wd;
      assign bus[k].out_ready = out_ready;
      assign en_o[k] = bus[k].en_out;
      assign irdy[k] = bus[k].in_ready;
      assign rdq[k]  = bus[k].rd_q;
      assign rsq[k]  = bus[k].rs_q;
      reg_file_param #(.DW(16), .NREG(k == 2 ? 3 : 4), .AW(2),
                       .BYPASS(k == 1 ? 0 : 1), .ZERO_R0(k == 2 ? 1 : 0))
         dut (.clk(clk), .rst(rst), .bus(bus[k]));
   end

   typedef struct {
      logic        chk;
      logic        we;
      logic [1:0]  wa;
      logic [15:0] wd;
      logic        en;
      logic [1:0]  rd, rs;
      logic        ordy;
      logic        xen;
      logic [15:0] xrd, xrs;
   } vec_t;

   typedef struct packed {
      logic [2:0][15:0] rd;
      logic [2:0][15:0] rs;
   } res_t;

   int          n_vec = 0, n_bad = 0;
   int          nreg [3] = '{4, 4, 3};
   bit          byp  [3] = '{1, 0, 1};
   bit          zr   [3] = '{0, 0, 1};
   logic [15:0] tm [3][4];
   logic        m_en;
   res_t        held;
   res_t        sq [$];
   vec_t        tbl [17];

   function automatic vec_t mk(logic chk, logic w, logic [1:0] a, logic [15:0] d, logic e,
                               logic [1:0] r1, logic [1:0] r2, logic o,
                               logic xe, logic [15:0] x1, logic [15:0] x2);
      vec_t v;
      v.chk = chk; v.we = w; v.wa = a; v.wd = d; v.en = e; v.rd = r1; v.rs = r2;
      v.ordy = o; v.xen = xe; v.xrd = x1; v.xrs = x2;
      return v;
   endfunction

   function automatic bit wvalid(int k, logic w, logic [1:0] a);
      return w && (int'(a) < nreg[k]) && !(zr[k] && a == 2'd0);
   endfunction

   function automatic logic [15:0] rv(int k, logic [1:0] a, vec_t v);
      if (int'(a) >= nreg[k]) return 16'h0;
      if (zr[k] && a == 2'd0) return 16'h0;
      if (byp[k] && wvalid(k, v.we, v.wa) && v.wa == a) return v.wd;
      return tm[k][a];
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 4; i++) tm[k][i] = 16'h0;
      m_en = 1'b0;
      held = '0;
      sq.delete();
   endtask

   task automatic compare_all();
      res_t e;
      e = (m_en && sq.size() > 0) ? sq[0] : held;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("en_out[%0d]", k), {15'h0, en_o[k]}, {15'h0, m_en});
         chk($sformatf("in_ready[%0d]", k), {15'h0, irdy[k]}, {15'h0, (!m_en || out_ready)});
         chk($sformatf("rd_q[%0d]", k), rdq[k], e.rd[k]);
         chk($sformatf("rs_q[%0d]", k), rsq[k], e.rs[k]);
      end
   endtask

   task automatic cycle(input vec_t v);
      res_t r;
      logic acc;
      we = v.we; wa = v.wa; wd = v.wd;
      en_in = v.en; rd_addr = v.rd; rs_addr = v.rs; out_ready = v.ordy;
      acc = v.en && (!m_en || v.ordy);
      for (int k = 0; k < 3; k++) begin
         r.rd[k] = rv(k, v.rd, v);
         r.rs[k] = rv(k, v.rs, v);
      end
      if (m_en && v.ordy && sq.size() > 0) held = sq.pop_front();
      if (acc) begin
         sq.push_back(r);
         m_en = 1'b1;
      end else if (v.ordy) begin
         m_en = 1'b0;
      end
      for (int k = 0; k < 3; k++)
         if (wvalid(k, v.we, v.wa)) tm[k][v.wa] = v.wd;
      @(posedge clk);
      #1;
      compare_all();
      if (v.chk) begin
         chk("tbl_en_out", {15'h0, en_o[0]}, {15'h0, v.xen});
         chk("tbl_rd_q", rdq[0], v.xrd);
         chk("tbl_rs_q", rsq[0], v.xrs);
      end
   endtask

   initial begin
      // chk, we, wa, wd, en, rd, rs, ordy | expected en_out, rd_q, rs_q of the default config
      tbl[0]  = mk(1, 1, 0, 16'h1111, 0, 0, 0, 1, 0, 16'h0,    16'h0);
      tbl[1]  = mk(1, 1, 1, 16'h2222, 0, 0, 0, 1, 0, 16'h0,    16'h0);
      tbl[2]  = mk(1, 1, 2, 16'h3333, 0, 0, 0, 1, 0, 16'h0,    16'h0);
      tbl[3]  = mk(1, 1, 3, 16'h4444, 0, 0, 0, 1, 0, 16'h0,    16'h0);
      tbl[4]  = mk(1, 0, 0, 16'h0,    1, 2, 1, 1, 1, 16'h3333, 16'h2222);
      tbl[5]  = mk(1, 1, 3, 16'hBEEF, 1, 3, 3, 1, 1, 16'hBEEF, 16'hBEEF);
      tbl[6]  = mk(1, 0, 0, 16'h0,    1, 3, 0, 1, 1, 16'hBEEF, 16'h1111);
      tbl[7]  = mk(1, 0, 0, 16'h0,    1, 0, 1, 1, 1, 16'h1111, 16'h2222);
      tbl[8]  = mk(1, 1, 0, 16'h5555, 1, 1, 1, 0, 1, 16'h1111, 16'h2222);
      tbl[9]  = mk(1, 0, 0, 16'h0,    1, 0, 0, 0, 1, 16'h1111, 16'h2222);
      tbl[10] = mk(1, 0, 0, 16'h0,    1, 0, 0, 0, 1, 16'h1111, 16'h2222);
      tbl[11] = mk(1, 0, 0, 16'h0,    1, 0, 0, 1, 1, 16'h5555, 16'h5555);
      tbl[12] = mk(1, 0, 0, 16'h0,    0, 0, 0, 1, 0, 16'h5555, 16'h5555);
      tbl[13] = mk(1, 0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h5555, 16'h5555);
      tbl[14] = mk(1, 1, 3, 16'h7777, 1, 3, 2, 0, 1, 16'h7777, 16'h3333);
      tbl[15] = mk(1, 1, 0, 16'hFFFF, 1, 0, 0, 1, 1, 16'hFFFF, 16'hFFFF);
      tbl[16] = mk(1, 0, 0, 16'h0,    1, 0, 3, 1, 1, 16'hFFFF, 16'h7777);

      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();

      for (int i = 0; i < 17; i++) cycle(tbl[i]);

      // Stall holding reg2, then reset between clock edges.
      cycle(mk(1, 0, 0, 16'h0, 1, 2, 2, 1, 1, 16'h3333, 16'h3333));
      cycle(mk(1, 0, 0, 16'h0, 0, 0, 0, 0, 1, 16'h3333, 16'h3333));
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(mk(1, 0, 0, 16'h0, 1, 1, 2, 1, 1, 16'h0, 16'h0));
      cycle(mk(1, 0, 0, 16'h0, 1, 3, 0, 1, 1, 16'h0, 16'h0));
      cycle(mk(1, 0, 0, 16'h0, 0, 0, 0, 1, 0, 16'h0, 16'h0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised general-purpose register file for the CPU datapath, and the successor to the fixed 4x16 register group.
- One write port and two registered read ports (rd, rs); read data feeds the ALU operand registers (alu_a / alu_b).
- New relative to the 4x16 group: configurable width and depth, a valid/ready read handshake with backpressure, write-to-read bypass, and an optional hard-wired zero register.

Parameters:
DW, 16, data width of each register and of all data ports
NREG, 4, number of registers (2..2^AW)
AW, 2, register address width; NREG <= 2^AW required
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = old contents read
ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; clears all state
en_in  input  1  read request valid
in_ready  output  1  read request can be accepted (combinational)
rd_addr  input  AW  destination-register read address
rs_addr  input  AW  source-register read address
we  input  1  write enable
wa  input  AW  write address
wd  input  DW  write data
en_out  output  1  read result valid
out_ready  input  1  downstream accepts read result
rd_q  output  DW  registered data of rd_addr
rs_q  output  DW  registered data of rs_addr

Behaviour:
Reset (rst=1, asynchronous, takes effect immediately and holds while asserted):
- All NREG registers = 0.
- en_out = 0, rd_q = 0, rs_q = 0.
- An in-flight write or read request is discarded.
- in_ready = 1 while en_out = 0.

Write port:
- On posedge with we=1, write is "valid" if wa < NREG and not (ZERO_R0=1 and wa=0). A valid write sets mem[wa] <= wd.
- Invalid writes are silently dropped; no error flag.
- Writes are independent of the read handshake and are accepted even while outputs are stalled.

Read value function rv(a):
- a >= NREG -> 0.
- ZERO_R0=1 and a=0 -> 0.
- BYPASS=1 and a valid write this cycle with wa=a -> wd.
- Otherwise mem[a] (pre-edge contents).

Read handshake:
- in_ready = !en_out | out_ready.
- Accept (posedge, en_in & in_ready): en_out <= 1, rd_q <= rv(rd_addr), rs_q <= rv(rs_addr). Latency is 1 cycle.
- Drain (posedge, !accept & en_out & out_ready): en_out <= 0; rd_q and rs_q hold their last values.
- Stall (en_out & !out_ready): en_out, rd_q and rs_q all hold. en_in is ignored (in_ready=0).
- Captured outputs are snapshots: later writes to the same register do not alter held rd_q / rs_q.
- Back-to-back accepts with out_ready=1 sustain one result per cycle.

Addressing and width:
- rd_addr = rs_addr is legal; both outputs then carry the same value.
- No arithmetic is performed; data passes at DW bits unchanged.

Test Plan:
- Reset/write/read, defaults: rst pulse; write 0x1111, 0x2222, 0x3333, 0x4444 to regs 0..3; en_in with rd=2, rs=1, out_ready=1 -> next cycle en_out=1, rd_q=0x3333, rs_q=0x2222.
- Bypass: reg3=0x4444; same cycle we=1, wa=3, wd=0xBEEF, en_in=1, rd=3, rs=3 -> BYPASS=1: rd_q=rs_q=0xBEEF; BYPASS=0: both 0x4444, and the next read returns 0xBEEF.
- Backpressure: accept rd=0 (0x1111) with out_ready=0 held 3 cycles; meanwhile write reg0=0x5555 and drive en_in -> in_ready=0, rd_q stays 0x1111 for all 3 cycles; out_ready=1 -> en_out drops, or the pending en_in is accepted and returns 0x5555.
- ZERO_R0=1: write 0xFFFF to reg0 -> reading reg0 returns 0, and bypass does not forward 0xFFFF.
- Out of range: NREG=3, AW=2; write to wa=3 ignored; rd_addr=3 -> rd_q=0.
- Async reset mid-stall: en_out=1, rd_q=0x3333, rst asserted between clock edges -> en_out, rd_q and rs_q go to 0 immediately; after release, reading any register returns 0.
